// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared data-memory interface definitions
// FSM encoding, data-memory base address and word-to-halfword mapping, reused by MEM stage and bench.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam int DATA_MEM_BASE = 1024;

  // SRAM location LSB selecting which half of the 32-bit word is transferred
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - loadable down-counter flagging the last cycle of an SRAM phase
// last is the current-cycle flag; last_next is what last will be after the coming edge.
module sram_wait_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last,
  output logic         last_next
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last      = (count_q == '0);
  assign last_next = (count_d == '0);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - MEM-stage data memory responder, one 32-bit word as two 16-bit SRAM accesses
// Optional range checking with err pulse when SRAM_RANGE_CHECK_EN is defined.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int ADDR_BASE  = DATA_MEM_BASE,
  parameter int SRAM_AW    = 18,
  parameter int ACC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int IW = SRAM_AW - 1;
  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(ACC_CYCLES - 1);

  mem_state_e         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [15:0]        hold_q, hold_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;

  logic        req, oor;
  logic        cnt_load, cnt_dec, cnt_last, cnt_last_next;
  logic [31:0] word_off;

  assign req      = rd_en | wr_en;
  assign word_off = word_offset(address, 32'(ADDR_BASE));

`ifdef SRAM_RANGE_CHECK_EN
  assign oor = (address < 32'(ADDR_BASE)) || (address[1:0] != 2'b00) || (word_off[31:IW] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[1:0], word_off[31:IW]};
  assign oor = 1'b0;
`endif

  assign cnt_load = ((state_q == ST_IDLE) && req && !oor) || ((state_q == ST_LO) && cnt_last);
  assign cnt_dec  = (state_q == ST_LO) || (state_q == ST_HI);

  sram_wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .last     (cnt_last),
    .last_next(cnt_last_next)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    hold_d   = hold_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d   = word_off[IW-1:0];
          wdata_d = wdata;
          write_d = wr_en;
          state_d = oor ? ST_DONE : ST_LO;
          err_d   = oor;
        end
      end
      ST_LO: begin
        if (cnt_last) begin
          state_d = ST_HI;
          if (!write_q) hold_d = sram_dq_in;
        end
      end
      ST_HI: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          if (!write_q) rdata_d = {sram_dq_in, hold_q};
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are registered, so they are computed for the state being entered
    if (state_d == ST_LO) begin
      addr_d   = {idx_d, HALF_LO};
      dq_out_d = wdata_d[15:0];
    end else if (state_d == ST_HI) begin
      addr_d   = {idx_d, HALF_HI};
      dq_out_d = wdata_d[31:16];
    end
    oe_d   = write_d && ((state_d == ST_LO) || (state_d == ST_HI));
    we_n_d = !(oe_d && cnt_last_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      hold_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= '0;
      oe_q     <= 1'b0;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      hold_q   <= hold_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
    end
  end

  assign ready       = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - randomized bench for sram_controller with transaction-level reference model
// Honours SRAM_RANGE_CHECK_EN to match the build of the design.
module tb_sram_controller;
  import sram_controller_pkg::DATA_MEM_BASE;

  localparam int ACC    = 2;
  localparam int AW     = 18;
  localparam int DONE_T = 2 * ACC + 1;
  localparam logic [31:0] BASE = 32'(DATA_MEM_BASE);
`ifdef SRAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, wdata = '0, rdata;
  logic ready, err, sram_dq_oe, sram_we_n;
  logic [AW-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in = '0;
  int total = 0, bad = 0, cyc = 0;

  sram_controller #(.ADDR_BASE(DATA_MEM_BASE), .SRAM_AW(AW), .ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Behavioural async SRAM with a deterministic power-up pattern
  logic [15:0] sram_mem [int];
  typedef struct { int c; int a; int d; } wr_ev_t;
  wr_ev_t wr_log[$];

  function automatic logic [15:0] dflt(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] sram_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : dflt(a);
  endfunction

  always @(negedge clk) begin
    if (rst && !sram_we_n) begin
      sram_mem[int'(sram_addr)] = sram_dq_out;
      wr_log.push_back('{cyc, int'(sram_addr), int'(sram_dq_out)});
    end
    sram_dq_in = sram_rd(int'(sram_addr));
  end

  // Reference model: word-level shadow memory plus the cycle offset inside a transaction
  logic [31:0] shadow [int];
  int t = -1;
  int m_idx = 0;
  bit m_wr = 1'b0, m_oor = 1'b0;
  logic [31:0] m_wd = '0, exp_rdata = '0;

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return int'(off % (32'd1 << (AW - 1)));
  endfunction

  function automatic bit oor_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return (a < BASE) || (a % 4 != 0) || (off >= (32'd1 << (AW - 1)));
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    return shadow.exists(idx) ? shadow[idx] : {dflt(2 * idx + 1), dflt(2 * idx)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t = -1;
      exp_rdata = '0;
    end else if (t < 0) begin
      if (rd_en || wr_en) begin
        m_wr  = wr_en;
        m_idx = idx_of(address);
        m_wd  = wdata;
        m_oor = RC && oor_of(address);
        t = m_oor ? DONE_T : 1;
      end
    end else if (t < 2 * ACC) begin
      t++;
    end else if (t == 2 * ACC) begin
      t = DONE_T;
      if (m_wr) shadow[m_idx] = m_wd;
      else exp_rdata = model_read(m_idx);
    end else begin
      t = -1;
    end
  end

  always @(negedge clk) begin
    int h;
    if (rst) begin
      chk("rdata", rdata, exp_rdata);
      if (t < 0) begin
        chk("idle_ready", ready, !(rd_en || wr_en));
        chk("idle_we_n", sram_we_n, 1);
        chk("idle_oe", sram_dq_oe, 0);
        chk("idle_err", err, 0);
      end else if (t <= 2 * ACC) begin
        h = (t > ACC) ? 1 : 0;
        chk("ph_addr", sram_addr, m_idx * 2 + h);
        chk("ph_oe", sram_dq_oe, m_wr);
        if (m_wr) chk("ph_dq", sram_dq_out, h ? m_wd[31:16] : m_wd[15:0]);
        chk("ph_we_n", sram_we_n, !(m_wr && (t == ACC || t == 2 * ACC)));
        chk("ph_ready", ready, 0);
        chk("ph_err", err, 0);
      end else begin
        chk("done_ready", ready, 1);
        chk("done_we_n", sram_we_n, 1);
        chk("done_oe", sram_dq_oe, 0);
        chk("done_err", err, m_oor);
      end
    end
  end

  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit drop, output int c0, output int rc, output logic e);
    rd_en = r; wr_en = w; address = a; wdata = d;
    c0 = cyc; rc = -1; e = 1'b0;
    if (drop) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        rc = cyc;
        e = err;
        break;
      end
    end
    if (rc < 0) begin
      total++; bad++;
      $display("FAIL txn_timeout: got no ready want ready within 40 cycles (addr %0h)", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int c0, rc, c1, rc1, sel, typ;
    logic e;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe", sram_dq_oe, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq", sram_dq_out, 0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;

    wr_log.delete();
    txn(0, 1, 32'd1024, 32'hDEADBEEF, 0, c0, rc, e);
    chk("t2_ready_cyc", rc - c0, 5);
    chk("t2_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t2_w0_cyc", wr_log[0].c - c0, 2);
      chk("t2_w0_addr", wr_log[0].a, 0);
      chk("t2_w0_dq", wr_log[0].d, 32'hBEEF);
      chk("t2_w1_cyc", wr_log[1].c - c0, 4);
      chk("t2_w1_addr", wr_log[1].a, 1);
      chk("t2_w1_dq", wr_log[1].d, 32'hDEAD);
    end
    idle(1);

    txn(1, 0, 32'd1024, 32'h0, 0, c0, rc, e);
    chk("t3_ready_cyc", rc - c0, 5);
    chk("t3_rdata", rdata, 32'hDEADBEEF);
    idle(2);

    wr_log.delete();
    txn(0, 1, 32'd1028, 32'h12345678, 0, c0, rc1, e);
    txn(1, 0, 32'd1028, 32'h0, 0, c1, rc, e);
    chk("t4_b2b_period", c1 - c0, 6);
    chk("t4_ready_cyc", rc - c1, 5);
    chk("t4_rdata", rdata, 32'h12345678);
    if (wr_log.size() == 2) begin
      chk("t4_w0_addr", wr_log[0].a, 2);
      chk("t4_w1_addr", wr_log[1].a, 3);
    end else begin
      chk("t4_nwr", wr_log.size(), 2);
    end
    idle(1);

    wr_log.delete();
    txn(1, 1, 32'd1032, 32'h0000A5A5, 0, c0, rc, e);
    chk("t5_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t5_w0_addr", wr_log[0].a, 4);
      chk("t5_w0_dq", wr_log[0].d, 32'hA5A5);
      chk("t5_w1_addr", wr_log[1].a, 5);
      chk("t5_w1_dq", wr_log[1].d, 32'h0);
    end
    chk("t5_rdata", rdata, 32'h12345678);
    idle(1);

    wr_log.delete();
    txn(1, 0, 32'd1000, 32'h0, 0, c0, rc, e);
    chk("t6_ready_cyc", rc - c0, RC ? 1 : 5);
    chk("t6_err", e, RC);
    chk("t6_nwr", wr_log.size(), 0);
    chk("t6_rdata", rdata, RC ? 32'h12345678 : 32'hA5AFA5AE);
    idle(1);

    wr_log.delete();
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1036; wdata = 32'h11112222;
    @(posedge clk); #2;
    rst = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("t1_we_n", sram_we_n, 1);
    chk("t1_oe", sram_dq_oe, 0);
    chk("t1_rdata", rdata, 0);
    chk("t1_ready", ready, 1);
    chk("t1_err", err, 0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("t1_nwr", wr_log.size(), 0);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = BASE + 4 * $urandom_range(0, 15);
      else if (sel == 7) a = BASE + 4 * ((1 << (AW - 1)) + $urandom_range(0, 15));
      else if (sel == 8) a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else               a = $urandom_range(0, 1023);
      typ = $urandom_range(0, 2);
      txn(typ != 1, typ != 0, a, $urandom, ($urandom_range(0, 7) == 0), c0, rc, e);
      idle($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
